ifm_scatter: RTL
================

// Module: ifm_scatter
// PURPOSE
//  Read-side counterpart of the OFM flattening path. Issues one read-master request per op.
//  Strips the 4 KB alignment padding from the returned 512-bit stream. Deals payload words
//  round-robin into four per-port FIFOs feeding IFM ports 0..3. Sits between the AXI read
//  master (rmst_*) and the conv array input.
// PARAMETERS
//  DATA_WIDTH  512   stream/port word width (bits)
//  WORD_BYTE   64    bytes per word (DATA_WIDTH/8)
//  FIFO_ABITS  9     per-port FIFO depth = 2**FIFO_ABITS words
//  NUM_PORT    4     output ports (fixed 4; parameter documents intent only)
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    async active-low reset
//  op_start         in   1    1-cycle pulse: latch ifm_size/rmst_offset, start load
//  ifm_size         in   32   payload bytes
//  rmst_offset      in   64   payload byte address; bits[5:0] ignored
//  rmst_req         out  1    1-cycle request pulse to read master
//  rmst_addr        out  64   {offset[63:12],12'b0}
//  rmst_xfer_size   out  64   bytes requested, multiple of 64
//  rmst_done        in   1    read master finished transfer
//  tdata            in   512  stream data from read master
//  valid            in   1    stream valid
//  ready            out  1    stream ready
//  in_ifm_port0..3  out  512  per-port word (FIFO head)
//  in_ifm_port_v0..3 out 1    per-port valid (FIFO not empty)
//  port_rdy0..3     in   1    consumer pop; pop when v & rdy
//  g_stall          in   1    global stall; freezes stream acceptance
//  load_done        out  1    1-cycle pulse when op fully complete
//  busy             out  1    state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FIFOs empty; state IDLE; word counters and port pointer 0.
//  Arithmetic on op_start, latched:
//   H = offset[11:6] (head skip words)
//   P = ceil(ifm_size/64)
//   T = ceil((offset[11:0] + ifm_size)/64)
//   Tail = T - H - P
//   rmst_xfer_size = T*64
//  rmst_addr is combinational from the latched offset.
//  FSM:
//   IDLE -op_start-> REQ (rmst_req=1 for exactly one cycle) -> SKIP if H>0, else STREAM.
//   SKIP: ready=1, drop words; after H beats -> STREAM, or TAIL if P==0.
//   STREAM: ready = !g_stall & !full[ptr]; beat pushes tdata to FIFO[ptr]; ptr wraps 3->0.
//     After P beats -> TAIL if Tail>0, else WAIT.
//   TAIL: ready=1, drop words; after Tail beats -> WAIT.
//   WAIT: ready=0; leave on rmst_done & all FIFOs empty; pulse load_done -> IDLE.
//  Beat = valid & ready. tdata is never used outside STREAM. Data from a beat is visible on
//   the port one cycle later.
//  FIFO full: ready stays low until the target FIFO pops. No loss; other ports keep draining.
//  Simultaneous push/pop on the same FIFO (even when full) is legal.
//  op_start while busy: ignored.
//  rmst_done before all T beats: go to WAIT, drain FIFOs, finish normally.
//  ifm_size==0: REQ is still issued, no FIFO pushes.
//  Reset mid-op: immediate return to reset values; in-flight data discarded.
// CONFIGURATION
//  IFM_SCATTER_STATUS_EN defined:
//   adds output beat_cnt[31:0] (payload beats pushed this op, cleared on op_start);
//   adds output short_err (sticky until op_start; set when rmst_done arrives before T beats).
//  Not defined: ports absent; FSM behaviour identical.
// STRUCTURE
//  Shared package scatter_pkg:
//   state enum {IDLE,REQ,SKIP,STREAM,TAIL,WAIT}
//   WORD_BYTE and PAGE_BITS=12 constants
//   word-count typedef (32b)
//  Sub-module: port FIFOs reuse the codebase FifoType0 (data_width 512); no new sub-module.
//  Top holds FSM, counters, round-robin pointer, output mux.
// TESTING
//  1. offset=0x1000, size=256: addr=0x1000, xfer=256, H=0.
//     4 beats -> one word on each port 0..3; load_done after rmst_done.
//  2. offset=0x1080, size=192: addr=0x1000, xfer=320, H=2.
//     First 2 beats dropped, next 3 to ports 0,1,2.
//  3. offset=0x1FC0, size=64: xfer=4096, H=63, P=1.
//     Tail=0 per formula (T=64); word 63 -> port0, rest dropped.
//     Also check offset=0x1F80, size=64: T=63, Tail=0.
//  4. port_rdy0=0, push 4*2**FIFO_ABITS+1 beats: ready drops when FIFO0 is full at ptr=0.
//     Raise port_rdy0: resumes with no lost or duplicated words (scoreboard).
//  5. g_stall=1 for 10 cycles mid-STREAM -> ready=0, no pushes; resumes on correct port.
//  6. rst_n low mid-STREAM -> all outputs 0, FIFOs empty.
//     New op_start then completes case 1 correctly.
//     With IFM_SCATTER_STATUS_EN: early rmst_done -> short_err=1.

Source files
------------

// File: rtl/scatter_pkg.sv
// Shared types and constants for the IFM read/scatter path.
// Optional status outputs of ifm_scatter are enabled by IFM_SCATTER_STATUS_EN.
package scatter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SKIP,
      STREAM,
      TAIL,
      WAIT
   } state_t;

   localparam int WORD_BYTE = 64;
   localparam int PAGE_BITS = 12;

   typedef logic [31:0] word_cnt_t;

endpackage

// File: rtl/FifoType0.sv
// Single-clock FIFO, combinational head, power-of-two depth.
// Push and pop in the same cycle are legal even when full.
module FifoType0 #(
   parameter int data_width = 512,
   parameter int addr_bits  = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [data_width-1:0] wr_data,
   input  logic                  rd_en,
   output logic [data_width-1:0] rd_data,
   output logic                  empty,
   output logic                  full
);

   localparam logic [addr_bits:0] DEPTH = (addr_bits+1)'(2**addr_bits);

   logic [data_width-1:0] r_mem [2**addr_bits];
   logic [addr_bits-1:0]  r_wp;
   logic [addr_bits-1:0]  r_rp;
   logic [addr_bits:0]    r_cnt;
   logic                  w_wr;
   logic                  w_rd;

   assign empty   = (r_cnt == '0);
   assign full    = (r_cnt == DEPTH);
   assign w_rd    = rd_en && !empty;
   assign w_wr    = wr_en && (!full || rd_en);
   assign rd_data = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_rd) r_rp <= r_rp + 1'b1;
         unique case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/ifm_scatter.sv
// IFM loader: one page-aligned read request per op, strips padding, deals words to 4 ports.
// Define IFM_SCATTER_STATUS_EN to add the beat_cnt/short_err status outputs.
module ifm_scatter #(
   parameter int DATA_WIDTH = 512,
   parameter int WORD_BYTE  = 64,
   parameter int FIFO_ABITS = 9,
   parameter int NUM_PORT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_start,
   input  logic [31:0]           ifm_size,
   input  logic [63:0]           rmst_offset,
   output logic                  rmst_req,
   output logic [63:0]           rmst_addr,
   output logic [63:0]           rmst_xfer_size,
   input  logic                  rmst_done,
   input  logic [DATA_WIDTH-1:0] tdata,
   input  logic                  valid,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] in_ifm_port0,
   output logic [DATA_WIDTH-1:0] in_ifm_port1,
   output logic [DATA_WIDTH-1:0] in_ifm_port2,
   output logic [DATA_WIDTH-1:0] in_ifm_port3,
   output logic                  in_ifm_port_v0,
   output logic                  in_ifm_port_v1,
   output logic                  in_ifm_port_v2,
   output logic                  in_ifm_port_v3,
   input  logic                  port_rdy0,
   input  logic                  port_rdy1,
   input  logic                  port_rdy2,
   input  logic                  port_rdy3,
   input  logic                  g_stall,
   output logic                  load_done,
   output logic                  busy
`ifdef IFM_SCATTER_STATUS_EN
   ,
   output logic [31:0]           beat_cnt,
   output logic                  short_err
`endif
);

   import scatter_pkg::*;

   localparam int WSH = $clog2(WORD_BYTE);

   state_t                 r_state;
   logic [63:PAGE_BITS]    r_page;
   logic [63:0]            r_xfer;
   word_cnt_t              r_h;
   word_cnt_t              r_p;
   word_cnt_t              r_tail;
   word_cnt_t              r_cnt;
   logic [1:0]             r_ptr;
   logic                   r_req;
   logic                   r_done_seen;
   logic                   r_load_done;

   logic [NUM_PORT-1:0]    w_full;
   logic [NUM_PORT-1:0]    w_empty;
   logic [NUM_PORT-1:0]    w_push;
   logic [NUM_PORT-1:0]    w_pop;
   logic [NUM_PORT-1:0]    w_rdy;
   logic [DATA_WIDTH-1:0]  w_head [NUM_PORT];
   logic [33:0]            w_p_sum;
   logic [33:0]            w_t_sum;
   word_cnt_t              w_h;
   word_cnt_t              w_p;
   word_cnt_t              w_t;
   word_cnt_t              w_lim;
   logic                   w_ready;
   logic                   w_beat;
   logic                   w_done;
   logic                   w_last;
   state_t                 w_after_skip;
   state_t                 w_after_stream;
   state_t                 w_phase_nxt;

   // Word counts: head skip, payload, and total page-aligned transfer.
   assign w_p_sum = {2'b0, ifm_size} + 34'(WORD_BYTE - 1);
   assign w_t_sum = {22'b0, rmst_offset[PAGE_BITS-1:0]} + w_p_sum;
   assign w_h     = word_cnt_t'(rmst_offset[PAGE_BITS-1:WSH]);
   assign w_p     = word_cnt_t'(w_p_sum >> WSH);
   assign w_t     = word_cnt_t'(w_t_sum >> WSH);

   always_comb begin
      w_ready = 1'b0;
      unique case (r_state)
         SKIP, TAIL: w_ready = 1'b1;
         STREAM:     w_ready = !g_stall && !w_full[r_ptr];
         default:    w_ready = 1'b0;
      endcase
   end

   assign w_beat = valid && w_ready;
   assign w_done = rmst_done || r_done_seen;

   assign w_after_stream = (r_tail != '0) ? TAIL : WAIT;
   assign w_after_skip   = (r_p != '0) ? STREAM : w_after_stream;

   always_comb begin
      w_lim       = r_tail;
      w_phase_nxt = WAIT;
      unique case (r_state)
         SKIP: begin
            w_lim       = r_h;
            w_phase_nxt = w_after_skip;
         end
         STREAM: begin
            w_lim       = r_p;
            w_phase_nxt = w_after_stream;
         end
         default: begin
            w_lim       = r_tail;
            w_phase_nxt = WAIT;
         end
      endcase
   end

   assign w_last = w_beat && (r_cnt == w_lim - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_page      <= '0;
         r_xfer      <= '0;
         r_h         <= '0;
         r_p         <= '0;
         r_tail      <= '0;
         r_cnt       <= '0;
         r_ptr       <= '0;
         r_req       <= 1'b0;
         r_done_seen <= 1'b0;
         r_load_done <= 1'b0;
      end else begin
         r_req       <= 1'b0;
         r_load_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (op_start) begin
                  r_state     <= REQ;
                  r_req       <= 1'b1;
                  r_page      <= rmst_offset[63:PAGE_BITS];
                  r_xfer      <= 64'(w_t) << WSH;
                  r_h         <= w_h;
                  r_p         <= w_p;
                  r_tail      <= w_t - w_h - w_p;
                  r_cnt       <= '0;
                  r_ptr       <= '0;
                  r_done_seen <= 1'b0;
               end
            end
            REQ: begin
               r_state <= (r_h != '0) ? SKIP : w_after_skip;
               if (rmst_done) r_done_seen <= 1'b1;
            end
            SKIP, STREAM, TAIL: begin
               if (w_beat) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_beat && r_state == STREAM) r_ptr <= r_ptr + 2'd1;
               // A done from the master ends the transfer even if beats are missing.
               if (w_done) r_state <= WAIT;
               else if (w_last) r_state <= w_phase_nxt;
               if (rmst_done) r_done_seen <= 1'b1;
            end
            WAIT: begin
               if (rmst_done) r_done_seen <= 1'b1;
               if (w_done && (&w_empty)) begin
                  r_state     <= IDLE;
                  r_load_done <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_rdy = {port_rdy3, port_rdy2, port_rdy1, port_rdy0};
   assign w_pop = ~w_empty & w_rdy;

   for (genvar g = 0; g < NUM_PORT; g++) begin : g_port
      assign w_push[g] = w_beat && (r_state == STREAM) && (r_ptr == 2'(g));
      FifoType0 #(
         .data_width (DATA_WIDTH),
         .addr_bits  (FIFO_ABITS)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (w_push[g]),
         .wr_data (tdata),
         .rd_en   (w_pop[g]),
         .rd_data (w_head[g]),
         .empty   (w_empty[g]),
         .full    (w_full[g])
      );
   end

   assign in_ifm_port0   = w_empty[0] ? '0 : w_head[0];
   assign in_ifm_port1   = w_empty[1] ? '0 : w_head[1];
   assign in_ifm_port2   = w_empty[2] ? '0 : w_head[2];
   assign in_ifm_port3   = w_empty[3] ? '0 : w_head[3];
   assign in_ifm_port_v0 = !w_empty[0];
   assign in_ifm_port_v1 = !w_empty[1];
   assign in_ifm_port_v2 = !w_empty[2];
   assign in_ifm_port_v3 = !w_empty[3];

   assign ready          = w_ready;
   assign rmst_req       = r_req;
   assign rmst_addr      = {r_page, PAGE_BITS'(0)};
   assign rmst_xfer_size = r_xfer;
   assign load_done      = r_load_done;
   assign busy           = (r_state != IDLE);

`ifdef IFM_SCATTER_STATUS_EN
   word_cnt_t r_beat_cnt;
   word_cnt_t r_tot;
   word_cnt_t r_t;
   logic      r_short;
   word_cnt_t w_tot_nxt;
   logic      w_xfer;

   assign w_xfer    = (r_state == SKIP) || (r_state == STREAM) ||
                      (r_state == TAIL);
   assign w_tot_nxt = r_tot + word_cnt_t'(w_beat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= '0;
         r_tot      <= '0;
         r_t        <= '0;
         r_short    <= 1'b0;
      end else if (r_state == IDLE && op_start) begin
         r_beat_cnt <= '0;
         r_tot      <= '0;
         r_t        <= w_t;
         r_short    <= 1'b0;
      end else begin
         if (w_xfer) r_tot <= w_tot_nxt;
         if (|w_push) r_beat_cnt <= r_beat_cnt + 1'b1;
         if (w_xfer && w_done && (w_tot_nxt < r_t)) r_short <= 1'b1;
      end
   end

   assign beat_cnt  = r_beat_cnt;
   assign short_err = r_short;
`endif

endmodule
